// File: rtl/rf_access_sequencer.sv
// Sequences one instruction at a time through operand read, execute wait and
// writeback against a 32x32 register file, with retire/write counters.
`timescale 1ns/1ps
module rf_access_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic             writes_rd,
    input  logic             result_valid,
    input  logic [31:0]      result_data,
    input  logic [31:0]      rf_rs1_dout,
    input  logic [31:0]      rf_rs2_dout,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    output logic [4:0]       rf_rd,
    output logic [31:0]      rf_rd_din,
    output logic             rf_write_enable,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    output logic             operands_valid,
    output logic             busy,
    output logic             wb_done,
    output logic [CNT_W-1:0] retire_count,
    output logic [CNT_W-1:0] write_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic             wrd_q;
    logic [31:0]      op_a_q, op_b_q, din_q;
    logic             opv_q, busy_q, wb_done_q, we_q;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] write_q, write_d;

    // Counter next-state: both advance only at the closing edge of WB.
    always_comb begin
        retire_d = retire_q;
        write_d  = write_q;
        if (state_q == S_WB) begin
            retire_d = retire_q + CNT_ONE;
            if (we_q) begin
                write_d = write_q + CNT_ONE;
            end else begin
                write_d = write_q;
            end
        end else begin
            retire_d = retire_q;
            write_d  = write_q;
        end
    end

    // Main sequencer FSM with all outputs registered; reset wins in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            rd_q      <= 5'd0;
            wrd_q     <= 1'b0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            din_q     <= 32'd0;
            opv_q     <= 1'b0;
            busy_q    <= 1'b0;
            wb_done_q <= 1'b0;
            we_q      <= 1'b0;
            retire_q  <= {CNT_W{1'b0}};
            write_q   <= {CNT_W{1'b0}};
        end else begin
            opv_q     <= 1'b0;
            wb_done_q <= 1'b0;
            we_q      <= 1'b0;
            retire_q  <= retire_d;
            write_q   <= write_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rs1_q   <= rs1;
                        rs2_q   <= rs2;
                        rd_q    <= rd;
                        wrd_q   <= writes_rd;
                        state_q <= S_READ;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_READ: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        op_a_q  <= rf_rs1_dout;
                        op_b_q  <= rf_rs2_dout;
                        opv_q   <= 1'b1;
                        state_q <= S_EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (result_valid) begin
                        din_q     <= result_data;
                        wb_done_q <= 1'b1;
                        // x0 is never written, whatever the instruction says.
                        we_q      <= wrd_q && (rd_q != 5'd0);
                        state_q   <= S_WB;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rf_rs1          = rs1_q;
    assign rf_rs2          = rs2_q;
    assign rf_rd           = rd_q;
    assign rf_rd_din       = din_q;
    // A reset landing in WB must not let the pending write reach the file.
    assign rf_write_enable = we_q & ~reset;
    assign op_a            = op_a_q;
    assign op_b            = op_b_q;
    assign operands_valid  = opv_q;
    assign busy            = busy_q;
    assign wb_done         = wb_done_q;
    assign retire_count    = retire_q;
    assign write_count     = write_q;

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Directed bench for rf_access_sequencer: expected operand and writeback
// records are queued at issue and checked by a monitor on each output pulse.
`timescale 1ns/1ps
module tb_rf_access_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset, start, flush, writes_rd, result_valid;
    logic [4:0]       rs1, rs2, rd;
    logic [31:0]      result_data, rf_rs1_dout, rf_rs2_dout;
    logic [4:0]       rf_rs1, rf_rs2, rf_rd;
    logic [31:0]      rf_rd_din, op_a, op_b;
    logic             rf_write_enable, operands_valid, busy, wb_done;
    logic [CNT_W-1:0] retire_count, write_count;

    typedef struct { logic [31:0] a; logic [31:0] b; } ops_t;
    typedef struct { logic [4:0] rd; logic [31:0] din; logic we; } wb_t;

    ops_t ops_q[$];
    wb_t  wb_q[$];
    ops_t mon_o;
    wb_t  mon_w;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf_mem [32];

    rf_access_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .rs1(rs1), .rs2(rs2), .rd(rd), .writes_rd(writes_rd),
        .result_valid(result_valid), .result_data(result_data),
        .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_rd_din(rf_rd_din),
        .rf_write_enable(rf_write_enable), .op_a(op_a), .op_b(op_b),
        .operands_valid(operands_valid), .busy(busy), .wb_done(wb_done),
        .retire_count(retire_count), .write_count(write_count)
    );

    always #5 clk = ~clk;

    // Register file model: x2 starts at 0x2ffc, x0 hardwired to zero.
    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_mem[2] = 32'h0000_2ffc;
    end

    always @(posedge clk) begin
        if (rf_write_enable && rf_rd != 5'd0) rf_mem[rf_rd] <= rf_rd_din;
    end

    assign rf_rs1_dout = rf_mem[rf_rs1];
    assign rf_rs2_dout = rf_mem[rf_rs2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents operands or a writeback.
    always @(negedge clk) begin
        if (operands_valid) begin
            if (ops_q.size() == 0) begin
                chk("ops_unexpected", 32'd1, 32'd0);
            end else begin
                mon_o = ops_q.pop_front();
                chk("op_a", op_a, mon_o.a);
                chk("op_b", op_b, mon_o.b);
            end
        end
        if (wb_done) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_w = wb_q.pop_front();
                chk("wb_rd", 32'(rf_rd), 32'(mon_w.rd));
                chk("wb_din", rf_rd_din, mon_w.din);
                chk("wb_we", 32'(rf_write_enable), 32'(mon_w.we));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: normal, 1: flush+start held during WB, 2: reset during WB
    task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic w, input logic [31:0] res, input int dly,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic ewe, input int mode);
        ops_q.push_back('{a: ea, b: eb});
        wb_q.push_back('{rd: d, din: res, we: ewe});
        chk("issue_idle", 32'(busy), 32'd0);
        rs1 = a; rs2 = b; rd = d; writes_rd = w; start = 1'b1;
        step();
        start = 1'b0;
        chk("read_busy", 32'(busy), 32'd1);
        chk("read_rf_rs1", 32'(rf_rs1), 32'(a));
        chk("read_rf_rs2", 32'(rf_rs2), 32'(b));
        step();
        chk("exec_opv", 32'(operands_valid), 32'd1);
        repeat (dly) step();
        result_valid = 1'b1; result_data = res;
        step();
        result_valid = 1'b0;
        if (mode == 1) begin
            flush = 1'b1; start = 1'b1;
        end else if (mode == 2) begin
            reset = 1'b1;
        end
        step();
        flush = 1'b0; start = 1'b0; reset = 1'b0;
        chk("post_wb_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_op_a"}, op_a, 32'd0);
        chk({tag, "_op_b"}, op_b, 32'd0);
        chk({tag, "_rd"}, 32'(rf_rd), 32'd0);
        chk({tag, "_rs1"}, 32'(rf_rs1), 32'd0);
        chk({tag, "_din"}, rf_rd_din, 32'd0);
        chk({tag, "_we"}, 32'(rf_write_enable), 32'd0);
        chk({tag, "_wb"}, 32'(wb_done), 32'd0);
        chk({tag, "_ret"}, 32'(retire_count), 32'd0);
        chk({tag, "_wr"}, 32'(write_count), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; writes_rd = 1'b0;
        result_valid = 1'b0; result_data = 32'd0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        step(); step();
        reset = 1'b0;
        chk_zero("reset");

        // Basic instruction: x5 = 0x3000, operands from x2 / x0
        issue(5'd2, 5'd0, 5'd5, 1'b1, 32'h0000_3000, 2, 32'h0000_2ffc, 32'd0, 1'b1, 0);
        chk("t1_x5", rf_mem[5], 32'h0000_3000);
        chk("t1_ret", 32'(retire_count), 32'd1);
        chk("t1_wr", 32'(write_count), 32'd1);

        // Back-to-back read-after-write on x5
        issue(5'd0, 5'd0, 5'd5, 1'b1, 32'h0000_0011, 1, 32'd0, 32'd0, 1'b1, 0);
        issue(5'd5, 5'd2, 5'd6, 1'b0, 32'h0000_0077, 0, 32'h0000_0011, 32'h0000_2ffc, 1'b0, 0);
        chk("raw_x6", rf_mem[6], 32'd0);
        chk("raw_ret", 32'(retire_count), 32'd3);
        chk("raw_wr", 32'(write_count), 32'd2);

        // Write to x0 is suppressed but still retires
        issue(5'd0, 5'd0, 5'd0, 1'b1, 32'hdead_beef, 1, 32'd0, 32'd0, 1'b0, 0);
        chk("x0_val", rf_mem[0], 32'd0);
        chk("x0_ret", 32'(retire_count), 32'd4);
        chk("x0_wr", 32'(write_count), 32'd2);

        // Flush in READ: operands must not update
        rs1 = 5'd5; rs2 = 5'd2; rd = 5'd3; writes_rd = 1'b1; start = 1'b1;
        step();
        start = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fr_busy", 32'(busy), 32'd0);
        chk("fr_opv", 32'(operands_valid), 32'd0);
        chk("fr_op_a", op_a, 32'd0);
        chk("fr_op_b", op_b, 32'd0);
        chk("fr_ret", 32'(retire_count), 32'd4);
        chk("fr_wr", 32'(write_count), 32'd2);

        // Flush together with result_valid in EXEC: no writeback
        ops_q.push_back('{a: 32'h0000_2ffc, b: 32'h0000_0011});
        rs1 = 5'd2; rs2 = 5'd5; rd = 5'd7; writes_rd = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        flush = 1'b1; result_valid = 1'b1; result_data = 32'h0000_0099;
        step();
        flush = 1'b0; result_valid = 1'b0;
        chk("fe_busy", 32'(busy), 32'd0);
        chk("fe_wb", 32'(wb_done), 32'd0);
        chk("fe_we", 32'(rf_write_enable), 32'd0);
        chk("fe_din", rf_rd_din, 32'hdead_beef);
        chk("fe_ret", 32'(retire_count), 32'd4);
        chk("fe_wr", 32'(write_count), 32'd2);
        step();
        chk("fe_x7", rf_mem[7], 32'd0);

        // Flush and start during WB are ignored; write commits
        issue(5'd0, 5'd0, 5'd8, 1'b1, 32'h0000_1234, 0, 32'd0, 32'd0, 1'b1, 1);
        chk("fw_x8", rf_mem[8], 32'h0000_1234);
        chk("fw_ret", 32'(retire_count), 32'd5);
        chk("fw_wr", 32'(write_count), 32'd3);

        // Reset during WB: pending write dropped
        issue(5'd0, 5'd0, 5'd9, 1'b1, 32'h0000_0abc, 0, 32'd0, 32'd0, 1'b0, 2);
        chk_zero("rwb");
        chk("rwb_x9", rf_mem[9], 32'd0);

        // Reset during EXEC
        ops_q.push_back('{a: 32'h0000_0011, b: 32'h0000_1234});
        rs1 = 5'd5; rs2 = 5'd8; rd = 5'd10; writes_rd = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1; result_valid = 1'b1; result_data = 32'h0000_0005;
        step();
        reset = 1'b0; result_valid = 1'b0;
        chk_zero("rex");
        step();
        chk("rex_x10", rf_mem[10], 32'd0);
        chk("rex_idle", 32'(busy), 32'd0);

        // start and result_valid held high: one instruction per 4 cycles
        for (int i = 0; i < 4; i++) begin
            ops_q.push_back('{a: 32'd0, b: 32'd0});
            wb_q.push_back('{rd: 5'd0, din: 32'h0000_0055, we: 1'b0});
        end
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; writes_rd = 1'b0;
        result_data = 32'h0000_0055; result_valid = 1'b1; start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("held_busy", 32'(busy), (i % 4 == 0) ? 32'd0 : 32'd1);
            chk("held_wb", 32'(wb_done), (i % 4 == 3) ? 32'd1 : 32'd0);
        end
        start = 1'b0; result_valid = 1'b0;
        chk("held_ret", 32'(retire_count), 32'd4);

        // Retire counter wraps at 2^CNT_W
        for (int i = 0; i < 11; i++) begin
            issue(5'd0, 5'd0, 5'd0, 1'b0, 32'(i), 0, 32'd0, 32'd0, 1'b0, 0);
        end
        chk("wrap_15", 32'(retire_count), 32'd15);
        issue(5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_00ff, 0, 32'd0, 32'd0, 1'b0, 0);
        chk("wrap_0", 32'(retire_count), 32'd0);
        chk("wrap_wr", 32'(write_count), 32'd0);

        step();
        chk("ops_q_empty", 32'(ops_q.size()), 32'd0);
        chk("wb_q_empty", 32'(wb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
